// File: rtl/paquete_control.sv
// Shared definitions for the control unit: opcodes, T-state encodings and control-word layout.
package paquete_control;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        HALT = 3'd7
    } estado_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    // Control-word bit positions, shared by the datapath and the bench.
    localparam int unsigned CW_PC_LOAD   = 0;
    localparam int unsigned CW_PC_SAVE   = 1;
    localparam int unsigned CW_PC_INC    = 2;
    localparam int unsigned CW_MAR_SAVE  = 3;
    localparam int unsigned CW_RAM_LOAD  = 4;
    localparam int unsigned CW_RAM_SAVE  = 5;
    localparam int unsigned CW_IR_LOAD   = 6;
    localparam int unsigned CW_IR_SAVE   = 7;
    localparam int unsigned CW_A_LOAD    = 8;
    localparam int unsigned CW_A_SAVE    = 9;
    localparam int unsigned CW_B_SAVE    = 10;
    localparam int unsigned CW_ALU_LOAD  = 11;
    localparam int unsigned CW_ALU_RESTA = 12;
    localparam int unsigned CW_OUT_SAVE  = 13;
    localparam int unsigned CW_INSTR_FIN = 14;
    localparam int unsigned CW_HALT      = 15;
    localparam int unsigned CW_W         = 16;

    typedef logic [CW_W-1:0] cw_t;

    // Last T-state that carries strobes for a given opcode.
    function automatic estado_t ultimo_paso(input logic [OPCODE_W-1:0] op);
        estado_t r;
        case (op)
            OP_LDA, OP_STA: r = T4;
            OP_ADD, OP_SUB: r = T5;
            default:        r = T3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unidad_control_if.sv
// Control-unit bundle: IR/ALU status in, register strobes and status out.
interface unidad_control_if;
    import paquete_control::*;

    logic                ejecutar;
    logic [OPCODE_W-1:0] opcode;
    logic                flag_cero;
    logic                flag_acarreo;

    logic pc_load, pc_save, pc_inc;
    logic mar_save;
    logic ram_load, ram_save;
    logic ir_load, ir_save;
    logic a_load, a_save;
    logic b_save;
    logic alu_load, alu_resta;
    logic out_save;
    logic instr_fin;
    logic halt;
    logic [ESTADO_W-1:0] estado;

    modport master (
        input  ejecutar, opcode, flag_cero, flag_acarreo,
        output pc_load, pc_save, pc_inc, mar_save, ram_load, ram_save,
               ir_load, ir_save, a_load, a_save, b_save, alu_load, alu_resta,
               out_save, instr_fin, halt, estado
    );

    modport slave (
        output ejecutar, opcode, flag_cero, flag_acarreo,
        input  pc_load, pc_save, pc_inc, mar_save, ram_load, ram_save,
               ir_load, ir_save, a_load, a_save, b_save, alu_load, alu_resta,
               out_save, instr_fin, halt, estado
    );

endinterface

// File: rtl/decodificador_control.sv
// Combinational microcode: (T-state, opcode, flags) -> control word.
module decodificador_control
    import paquete_control::*;
#(
    parameter bit CICLOS_FIJOS = 1'b0
) (
    input  estado_t             estado_i,
    input  logic                ejecutar_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                flag_cero_i,
    input  logic                flag_acarreo_i,
    output cw_t                 cw_o
);

    // Strobes for the current step plus end-of-instruction marker.
    always_comb begin
        cw_o = '0;
        case (estado_i)
            T1: begin
                cw_o[CW_PC_LOAD]  = ejecutar_i;
                cw_o[CW_MAR_SAVE] = ejecutar_i;
            end
            T2: begin
                cw_o[CW_RAM_LOAD] = 1'b1;
                cw_o[CW_IR_SAVE]  = 1'b1;
                cw_o[CW_PC_INC]   = 1'b1;
            end
            T3: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw_o[CW_IR_LOAD]  = 1'b1;
                        cw_o[CW_MAR_SAVE] = 1'b1;
                    end
                    OP_LDI: begin
                        cw_o[CW_IR_LOAD] = 1'b1;
                        cw_o[CW_A_SAVE]  = 1'b1;
                    end
                    OP_JMP: begin
                        cw_o[CW_IR_LOAD] = 1'b1;
                        cw_o[CW_PC_SAVE] = 1'b1;
                    end
                    OP_JC: begin
                        cw_o[CW_IR_LOAD] = 1'b1;
                        cw_o[CW_PC_SAVE] = flag_acarreo_i;
                    end
                    OP_JZ: begin
                        cw_o[CW_IR_LOAD] = 1'b1;
                        cw_o[CW_PC_SAVE] = flag_cero_i;
                    end
                    OP_OUT: begin
                        cw_o[CW_A_LOAD]   = 1'b1;
                        cw_o[CW_OUT_SAVE] = 1'b1;
                    end
                    OP_HLT:  cw_o[CW_HALT] = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                case (opcode_i)
                    OP_LDA: begin
                        cw_o[CW_RAM_LOAD] = 1'b1;
                        cw_o[CW_A_SAVE]   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw_o[CW_RAM_LOAD]  = 1'b1;
                        cw_o[CW_B_SAVE]    = 1'b1;
                        cw_o[CW_ALU_RESTA] = (opcode_i == OP_SUB);
                    end
                    OP_STA: begin
                        cw_o[CW_A_LOAD]   = 1'b1;
                        cw_o[CW_RAM_SAVE] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    cw_o[CW_ALU_LOAD]  = 1'b1;
                    cw_o[CW_A_SAVE]    = 1'b1;
                    cw_o[CW_ALU_RESTA] = (opcode_i == OP_SUB);
                end
            end
            default: cw_o[CW_HALT] = 1'b1;
        endcase

        // Fixed-length mode pads every instruction out to T5; HLT never ends normally.
        if ((estado_i == T3 || estado_i == T4 || estado_i == T5) && opcode_i != OP_HLT) begin
            if (CICLOS_FIJOS)
                cw_o[CW_INSTR_FIN] = (estado_i == T5);
            else
                cw_o[CW_INSTR_FIN] = (estado_i == ultimo_paso(opcode_i));
        end
    end

endmodule

// File: rtl/unidad_control.sv
// T-state sequencer for the 8-bit bus datapath: state register, next-state logic, reset gating.
module unidad_control
    import paquete_control::*;
#(
    parameter bit CICLOS_FIJOS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    unidad_control_if.master  bus
);

    estado_t estado_q, estado_d;
    cw_t     cw;
    cw_t     ctrl_c;

    decodificador_control #(
        .CICLOS_FIJOS (CICLOS_FIJOS)
    ) u_dec (
        .estado_i       (estado_q),
        .ejecutar_i     (bus.ejecutar),
        .opcode_i       (bus.opcode),
        .flag_cero_i    (bus.flag_cero),
        .flag_acarreo_i (bus.flag_acarreo),
        .cw_o           (cw)
    );

    // Advance through T-states; HLT parks in HALT, end-of-instruction returns to T1.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            T1:         if (bus.ejecutar) estado_d = T2;
            T2:         estado_d = T3;
            T3, T4, T5: begin
                if (cw[CW_HALT])
                    estado_d = HALT;
                else if (cw[CW_INSTR_FIN])
                    estado_d = T1;
                else
                    estado_d = estado_t'(estado_q + 3'd1);
            end
            HALT:       estado_d = HALT;
            default:    estado_d = T1;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset)
            estado_q <= T1;
        else
            estado_q <= estado_d;
    end

    // No strobe may reach the datapath while reset is held.
    assign ctrl_c = reset ? '0 : cw;

    assign bus.pc_load   = ctrl_c[CW_PC_LOAD];
    assign bus.pc_save   = ctrl_c[CW_PC_SAVE];
    assign bus.pc_inc    = ctrl_c[CW_PC_INC];
    assign bus.mar_save  = ctrl_c[CW_MAR_SAVE];
    assign bus.ram_load  = ctrl_c[CW_RAM_LOAD];
    assign bus.ram_save  = ctrl_c[CW_RAM_SAVE];
    assign bus.ir_load   = ctrl_c[CW_IR_LOAD];
    assign bus.ir_save   = ctrl_c[CW_IR_SAVE];
    assign bus.a_load    = ctrl_c[CW_A_LOAD];
    assign bus.a_save    = ctrl_c[CW_A_SAVE];
    assign bus.b_save    = ctrl_c[CW_B_SAVE];
    assign bus.alu_load  = ctrl_c[CW_ALU_LOAD];
    assign bus.alu_resta = ctrl_c[CW_ALU_RESTA];
    assign bus.out_save  = ctrl_c[CW_OUT_SAVE];
    assign bus.instr_fin = ctrl_c[CW_INSTR_FIN];
    assign bus.halt      = ctrl_c[CW_HALT];
    assign bus.estado    = estado_q;

    // Single bus driver per cycle.
    a_bus_unico: assert property (@(posedge clk) disable iff (reset)
        $onehot0({bus.pc_load, bus.ram_load, bus.ir_load, bus.a_load, bus.alu_load}));

    // A jump and an increment never compete for the PC.
    a_pc_unico: assert property (@(posedge clk) !(bus.pc_save && bus.pc_inc));

    // Only reset leaves HALT.
    a_halt_fijo: assert property (@(posedge clk)
        (estado_q == HALT && !reset) |=> (estado_q == HALT));

endmodule
